// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the CPU load/store
// path and one external requester. Serialises accesses, adds read wait-states
// and stalls the CPU while its access is pending.
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int MEM_LAT    = 1,   // read latency in cycles, 1..4
   parameter int STARVE_LIM = 3    // waiting cycles before ext beats the CPU
) (
   input  logic          clk,
   input  logic          reset,
   // CPU load/store port
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   // external requester port
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [31:0]   ext_wdata,
   output logic          ext_gnt,
   output logic          ext_rvalid,
   output logic [31:0]   ext_rdata,
   // data RAM port
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int SW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [2:0]    LAT_LAST   = 3'(MEM_LAT);

   typedef enum logic { IDLE, RD_WAIT } state_t;
   typedef enum logic { OWN_CPU, OWN_EXT } owner_t;

   state_t          state_q, state_d;
   owner_t          owner_q, owner_d;
   logic [2:0]      lat_cnt_q, lat_cnt_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            drop_q, drop_d;     // CPU abandoned its in-flight read

   logic            ext_win, cpu_win, rd_done, cpu_live;

   // State register; reset discards any in-flight read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_CPU;
         lat_cnt_q <= '0;
         starve_q  <= '0;
         drop_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
         starve_q  <= starve_d;
         drop_q    <= drop_d;
      end
   end

   // Arbitration, memory issue, read completion and starvation counting.
   always_comb begin
      // NOTE: every output and next-state value gets a default here so no
      // path through the case below can infer a latch.
      state_d    = state_q;
      owner_d    = owner_q;
      lat_cnt_d  = lat_cnt_q;
      drop_d     = drop_q;
      ext_win    = 1'b0;
      cpu_win    = 1'b0;
      rd_done    = 1'b0;
      cpu_live   = 1'b0;
      cpu_rdata  = '0;
      cpu_stall  = 1'b0;
      ext_gnt    = 1'b0;
      ext_rvalid = 1'b0;
      ext_rdata  = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state_q)
         IDLE: begin
            drop_d  = 1'b0;
            ext_win = ext_req && (!cpu_req || starve_q == STARVE_MAX);
            cpu_win = cpu_req && !ext_win;
            if (ext_win) begin
               mem_en    = 1'b1;
               mem_we    = ext_we;
               mem_addr  = ext_addr;
               mem_wdata = ext_wdata;
               ext_gnt   = 1'b1;
               if (!ext_we) begin
                  state_d   = RD_WAIT;
                  owner_d   = OWN_EXT;
                  lat_cnt_d = 3'd1;
               end
            end else if (cpu_win) begin
               mem_en    = 1'b1;
               mem_we    = cpu_we;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               if (!cpu_we) begin
                  state_d   = RD_WAIT;
                  owner_d   = OWN_CPU;
                  lat_cnt_d = 3'd1;
               end
            end
            // Stores complete in their winning cycle; loads and losers stall.
            cpu_stall = cpu_req && !(cpu_win && cpu_we);
         end

         RD_WAIT: begin
            rd_done  = (lat_cnt_q == LAT_LAST);
            cpu_live = (owner_q == OWN_CPU) && !drop_q && cpu_req;
            // A dropped cpu_req abandons the read; the data is discarded.
            if (owner_q == OWN_CPU && !cpu_req) drop_d = 1'b1;
            if (rd_done) begin
               state_d   = IDLE;
               lat_cnt_d = '0;
               drop_d    = 1'b0;
               if (cpu_live) cpu_rdata = mem_rdata;
               if (owner_q == OWN_EXT) begin
                  ext_rvalid = 1'b1;
                  ext_rdata  = mem_rdata;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
            cpu_stall = cpu_req && !(rd_done && cpu_live);
         end

         default: state_d = IDLE;
      endcase

      // Starvation counter runs in every state while ext waits ungranted.
      starve_d = starve_q;
      if (ext_gnt)
         starve_d = '0;
      else if (ext_req && starve_q != STARVE_MAX)
         starve_d = starve_q + SW'(1);

      // Outputs are held at zero for the whole reset assertion.
      if (!reset) begin
         cpu_rdata  = '0;
         cpu_stall  = 1'b0;
         ext_gnt    = 1'b0;
         ext_rvalid = 1'b0;
         ext_rdata  = '0;
         mem_en     = 1'b0;
         mem_we     = 1'b0;
         mem_addr   = '0;
         mem_wdata  = '0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// CPU/external traffic, all compared against a transaction-level model.
module tb_dmem_arbiter;

   localparam int AW         = 32;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_LIM = 3;

   logic          clk, reset;
   logic          cpu_req, cpu_we, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata, cpu_rdata;
   logic          ext_req, ext_we, ext_gnt, ext_rvalid;
   logic [AW-1:0] ext_addr;
   logic [31:0]   ext_wdata, ext_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
      .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with MEM_LAT cycles of read latency.
   logic [31:0] ram     [0:255];
   logic [31:0] rd_pipe [1:MEM_LAT];
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      rd_pipe[1] <= (mem_en && !mem_we) ? ram[mem_addr[9:2]] : 32'hxxxx_xxxx;
      for (int k = 2; k <= MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[MEM_LAT];

   // Reference model: expected memory contents plus the pending read.
   logic [31:0] ref_mem [0:255];
   int          rem       = 0;     // cycles until the pending read completes
   bit          own_ext   = 1'b0;
   bit          cpu_gone  = 1'b0;
   logic [31:0] rd_data   = '0;
   int          starve    = 0;
   bit          last_stall, last_gnt;
   // Outputs sampled in the most recent cycle.
   logic        s_en, s_we, s_gnt, s_stall, s_rv;
   logic [31:0] s_crd, s_erd;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      rem = 0; starve = 0; cpu_gone = 1'b0;
   endtask

   // One clock cycle: inputs are already driven; check outputs mid-cycle,
   // advance the model, then return just after the next rising edge.
   task automatic cycle();
      logic        e_en, e_we, e_gnt, e_stall, e_rv, e_cok;
      logic [31:0] e_addr, e_wd;
      bit          ext_wins, cpu_wins, done;
      e_en = 0; e_we = 0; e_gnt = 0; e_stall = 0; e_rv = 0; e_cok = 0;
      e_addr = '0; e_wd = '0;
      @(negedge clk);
      if (rem == 0) begin
         ext_wins = ext_req && (!cpu_req || starve == STARVE_LIM);
         cpu_wins = cpu_req && !ext_wins;
         if (ext_wins) begin
            e_en = 1; e_we = ext_we; e_addr = ext_addr; e_wd = ext_wdata; e_gnt = 1;
         end else if (cpu_wins) begin
            e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
         end
         e_stall = cpu_req && !(cpu_wins && cpu_we);
      end else begin
         done = (rem == 1);
         if (!own_ext && !cpu_req) cpu_gone = 1'b1;
         e_cok   = done && !own_ext && !cpu_gone;
         e_stall = cpu_req && !e_cok;
         e_rv    = done && own_ext;
      end
      s_en = mem_en; s_we = mem_we; s_gnt = ext_gnt; s_stall = cpu_stall;
      s_rv = ext_rvalid; s_crd = cpu_rdata; s_erd = ext_rdata;
      check("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      check("ext_gnt", {31'b0, ext_gnt}, {31'b0, e_gnt});
      check("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
      check("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, e_rv});
      if (e_en) begin
         check("mem_addr", mem_addr, e_addr);
         check("mem_wdata", mem_wdata, e_wd);
      end
      if (e_cok && cpu_req) check("cpu_rdata", cpu_rdata, rd_data);
      if (e_rv) check("ext_rdata", ext_rdata, rd_data);
      // advance model
      if (e_gnt) starve = 0;
      else if (ext_req && starve < STARVE_LIM) starve++;
      if (e_en && e_we) ref_mem[e_addr[9:2]] = e_wd;
      if (rem > 0) rem--;
      if (e_en && !e_we) begin
         rem = MEM_LAT; own_ext = e_gnt; cpu_gone = 1'b0;
         rd_data = ref_mem[e_addr[9:2]];
      end
      last_stall = e_stall; last_gnt = e_gnt;
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'b0, cpu_stall}, 32'd0);
      check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
      check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_gnt"}, {31'b0, ext_gnt}, 32'd0);
      check({tag, "_rvalid"}, {31'b0, ext_rvalid}, 32'd0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_ext_rdata"}, ext_rdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int gnt_at, rv_at;
      for (int i = 0; i < 256; i++) begin
         ram[i] = $urandom; ref_mem[i] = ram[i];
      end
      reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
      #3;
      cpu_req = 1; ext_req = 1;
      #1 check_all_zero("in_reset");
      cpu_req = 0; ext_req = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();

      // CPU store: zero wait.
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
      cycle();
      check("store_en", {31'b0, s_en}, 32'd1);
      check("store_we", {31'b0, s_we}, 32'd1);
      check("store_stall", {31'b0, s_stall}, 32'd0);
      cpu_wdata = 32'h12345678;
      cycle();
      // CPU load: MEM_LAT stall cycles, then data.
      cpu_we = 0;
      cycle(); check("load_stall0", {31'b0, s_stall}, 32'd1);
      cycle(); check("load_stall1", {31'b0, s_stall}, 32'd1);
      cycle(); check("load_stall2", {31'b0, s_stall}, 32'd0);
      check("load_data", s_crd, 32'h12345678);
      cpu_req = 0;

      // EXT write then CPU read of the same word.
      ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hA5A5A5A5;
      cycle(); check("extwr_gnt", {31'b0, s_gnt}, 32'd1);
      ext_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
      for (int i = 0; i < 6 && cpu_req; i++) begin
         cycle();
         if (!s_stall) begin
            check("raw_data", s_crd, 32'hA5A5A5A5);
            cpu_req = 0;
         end
      end
      if (cpu_req) begin
         check("raw_timeout", 32'd1, 32'd0);
         cpu_req = 0;
      end
      cycle();

      // Simultaneous reads: CPU first, ext after completion bubble.
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
      ext_req = 1; ext_we = 0; ext_addr = 32'h40;
      gnt_at = -1; rv_at = -1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (cpu_req && !s_stall) cpu_req = 0;
         if (s_gnt) begin gnt_at = i; ext_req = 0; end
         if (s_rv) begin rv_at = i; check("sim_ext_data", s_erd, 32'hA5A5A5A5); end
      end
      check("sim_gnt_cycle", gnt_at, 32'd3);
      check("sim_rvalid_cycle", rv_at, 32'd5);

      // Starvation: CPU stores every cycle, ext write held.
      ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h0BADF00D;
      cpu_req = 1; cpu_we = 1;
      for (int i = 0; i < 5; i++) begin
         cpu_addr = 32'(i) << 2; cpu_wdata = $urandom;
         cycle();
         check("starve_gnt", {31'b0, s_gnt}, (i == 3) ? 32'd1 : 32'd0);
         check("starve_stall", {31'b0, s_stall}, (i == 3) ? 32'd1 : 32'd0);
         if (s_gnt) begin
            ext_req = 0;
            check("starve_cleared", {30'b0, dut.starve_q}, 32'd0);
         end
      end
      cpu_req = 0;

      // Reset during an ext read in its wait state.
      ext_req = 1; ext_we = 0; ext_addr = 32'h80;
      cycle(); check("rst_rd_gnt", {31'b0, s_gnt}, 32'd1);
      ext_req = 0; cpu_req = 1; cpu_we = 0;
      reset = 1'b0;
      #1 check_all_zero("rst_mid_read");
      model_reset();
      repeat (2) @(posedge clk);
      #1 cpu_req = 0;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(); check("rst_no_rvalid", {31'b0, s_rv}, 32'd0);
      end
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
      cycle(); check("rst_idle_issue", {31'b0, s_en}, 32'd1);
      cpu_req = 0;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cycle();
         if (cpu_req && last_stall) begin
            if ($urandom_range(0, 15) == 0) cpu_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_req = 0;
         end else begin
            cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 32'($urandom_range(0, 15)) << 2; cpu_wdata = $urandom;
         end
         if (!(ext_req && !last_gnt)) begin
            if ($urandom_range(0, 2) == 0) begin
               ext_req = 1; ext_we = 1'($urandom_range(0, 1));
               ext_addr = 32'($urandom_range(0, 15)) << 2; ext_wdata = $urandom;
            end else begin
               ext_req = 0;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath's load/store path and one external requester, such as a UART program loader or sensor-log DMA.
- Serialises all accesses and inserts read wait-states.
- Asserts a stall to the CPU so that the PC register and register-file writeback hold while its access is pending.
- Sits between the datapath's memory address/write-data outputs and the data RAM.

Parameters:
AW, 32, address width of all address ports
MEM_LAT, 1, memory read latency in cycles (legal 1..4); mem_rdata valid MEM_LAT cycles after the issue cycle
STARVE_LIM, 3, consecutive cycles an ungranted ext_req may wait before it beats the CPU

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU load/store request, level, held until cpu_stall=0
cpu_we  in  1  1=store, 0=load
cpu_addr  in  AW  CPU byte address (ALU result)
cpu_wdata  in  32  store data (already byte-lane merged)
cpu_rdata  out  32  load data, valid in cycle cpu_req=1 and cpu_stall=0 for a load
cpu_stall  out  1  hold CPU state this cycle
ext_req  in  1  external request, level, held until ext_gnt
ext_we  in  1  1=write, 0=read
ext_addr  in  AW  external byte address
ext_wdata  in  32  external write data
ext_gnt  out  1  one-cycle pulse: request accepted/issued this cycle
ext_rvalid  out  1  one-cycle pulse: ext_rdata valid
ext_rdata  out  32  external read data
mem_en  out  1  memory access strobe (issue cycle only)
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address (passed through unchanged, low bits included)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data

Behaviour:
Reset:
- reset=0 asynchronously forces IDLE and clears lat_cnt, starve_cnt and the owner flag.
- While in reset, all outputs are 0, cpu_stall is 0, and rdata outputs are 0.
- An in-flight read is discarded; no ext_rvalid is produced after reset releases.

States:
- IDLE: issues at most one access per cycle. mem_en, mem_we, mem_addr and mem_wdata are driven combinationally from the winner in the same cycle.
- RD_WAIT: lat_cnt counts issued-read cycles and owner records CPU or EXT. No issue occurs in RD_WAIT.

Arbitration (IDLE only):
- CPU wins by default.
- EXT wins if ext_req=1 and either cpu_req=0 or starve_cnt==STARVE_LIM.
- starve_cnt increments (saturating at STARVE_LIM) each cycle ext_req=1 and ext_gnt=0, and clears on ext_gnt.

CPU access:
- Write: issued in the winning cycle and completes in it. cpu_stall=0 that cycle, giving zero wait for stores.
- Read: issue cycle N has cpu_stall=1, then the block enters RD_WAIT with lat_cnt=1.
- In cycle N+MEM_LAT: cpu_rdata=mem_rdata (combinational pass-through), cpu_stall=0, and the block returns to IDLE next cycle.
- Stall cycles for a read = MEM_LAT.

CPU losing arbitration, or arriving while in RD_WAIT: cpu_stall=1 every cycle until its own completion cycle.

EXT access:
- ext_gnt pulses in the issue cycle. A write completes there.
- For a read, ext_rvalid=1 and ext_rdata=mem_rdata in cycle N+MEM_LAT, then return to IDLE.
- The requester may present its next request in the cycle after ext_gnt.

Back-to-back: after a read completes, the next issue happens at the earliest on the following cycle (one bubble). Writes may issue every cycle.

Simultaneous: the losing requester's inputs are ignored. No internal queue; the requester holds its signals.

Protocol errors: if cpu_req drops while stalled, the access is abandoned.
- If the read is already issued, it finishes internally with data dropped and the CPU stalls no further.
- Same rule for ext_req before ext_gnt.

mem_en=0 whenever no issue occurs. mem_we=0 when mem_en=0.

Test Plan:
- Reset release, CPU store: addr 0x100, data 0xDEADBEEF -> mem_en=mem_we=1 same cycle, cpu_stall=0 throughout.
- CPU load with MEM_LAT=2, RAM[0x100]=0x12345678 -> cpu_stall=1 for 2 cycles, then cpu_rdata=0x12345678 with cpu_stall=0.
- Same-cycle cpu_req and ext_req (both reads), starve_cnt=0 -> CPU issued first. ext_gnt comes on the cycle after CPU read completion plus one bubble. ext_rvalid follows MEM_LAT later.
- CPU issues stores every cycle while ext_req is held, STARVE_LIM=3 -> ext_gnt on the 4th cycle, cpu_stall=1 that cycle only, starve_cnt back to 0.
- Assert reset=0 during an ext read in RD_WAIT -> all outputs are 0 immediately. After release, no ext_rvalid appears, and the state is IDLE.
- Alternate EXT write 0xA5A5A5A5 to 0x40, then CPU read of 0x40 -> cpu_rdata=0xA5A5A5A5, confirming write-then-read ordering.
